io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Parametrised arbiter that merges non-cacheable IO requests from NUM_REQUESTERS cores onto one external IO bus and returns tagged responses. It supports variable-latency slaves through an acknowledge handshake and aborts hung transactions with an error response. The block sits between the cores' IO request ports and the top-level non-cacheable memory interface.

## Interface
- NUM_REQUESTERS, 4: number of requesting cores (≥1); REQ_IDX_WIDTH = max(1, $clog2(NUM_REQUESTERS))
- ADDR_WIDTH, 32: IO address width
- DATA_WIDTH, 32: IO data width
- THREAD_IDX_WIDTH, 2: thread tag width
- TIMEOUT_CYCLES, 256: bus cycles before abort; 0 disables the timeout; counter width max(1, $clog2(TIMEOUT_CYCLES+1))

- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQUESTERS  per-requester request valid
- req_is_store  input  NUM_REQUESTERS  1 = write, 0 = read
- req_address  input  NUM_REQUESTERS×ADDR_WIDTH  per-requester address
- req_write_data  input  NUM_REQUESTERS×DATA_WIDTH  per-requester store data
- req_thread_idx  input  NUM_REQUESTERS×THREAD_IDX_WIDTH  per-requester thread tag
- req_ready  output  NUM_REQUESTERS  one-hot accept pulse, combinational
- rsp_valid  output  1  response valid, single-cycle pulse
- rsp_requester  output  REQ_IDX_WIDTH  index of the requester that issued the transaction
- rsp_thread_idx  output  THREAD_IDX_WIDTH  echoed thread tag
- rsp_read_value  output  DATA_WIDTH  read data; 0 for stores and errors
- rsp_error  output  1  1 = transaction timed out
- io_read_en  output  1  bus read strobe, held until ack or abort
- io_write_en  output  1  bus write strobe, held until ack or abort
- io_address  output  ADDR_WIDTH  bus address, registered
- io_write_data  output  DATA_WIDTH  bus store data, registered
- io_ack  input  1  slave completion; valid only while a strobe is high
- io_read_data  input  DATA_WIDTH  read data, sampled on the io_ack cycle

## Operation
- States: IDLE, BUS.
- IDLE: if any req_valid, the round-robin arbiter selects one requester.
  - req_ready[g] pulses high for that cycle.
  - is_store, address, write data, thread tag, and index g are latched.
  - The timeout counter is cleared and the state goes to BUS.
- Round robin: search starts at (last_grant+1) mod NUM_REQUESTERS. After reset last_grant = NUM_REQUESTERS-1, so requester 0 has first priority. With NUM_REQUESTERS=1, req_ready = req_valid & IDLE.
- BUS: exactly one strobe is high (io_write_en = latched is_store, io_read_en = its inverse). Address and data are held stable. req_ready is all zero.
  - io_ack=1: the response is registered (read_value = io_read_data for reads, 0 for stores; rsp_error=0). The state goes to IDLE.
  - io_ack=0 and the counter equals TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): abort. The strobes drop, a response with rsp_error=1 and rsp_read_value=0 is registered, and the state goes to IDLE.
  - Otherwise the counter increments; it saturates and never wraps.
- io_ack and terminal count in the same cycle: ack wins, no error.
- io_ack in IDLE is ignored.
- A requester must hold its req_valid and payload stable until req_ready; dropping it earlier is permitted and simply withdraws the request.

## Timing
- Reset (reset_n low, asynchronous) puts the block in the following state, overriding any in-flight transaction with no response generated:
  - state = IDLE; all req_ready, rsp_valid, io_read_en, io_write_en = 0
  - rsp_requester, rsp_thread_idx, rsp_read_value, rsp_error, io_address, io_write_data = 0
  - counter = 0; last_grant = NUM_REQUESTERS-1
- Grant at cycle T: strobes and address are high from T+1.
- Zero-wait slave (io_ack at T+1): rsp_valid at T+2.
- General case: rsp_valid is high for one cycle, the cycle after io_ack. In that same cycle the block is in IDLE and may grant again, giving back-to-back throughput of one transaction per 2 cycles with a zero-wait slave.
- Timeout: grant at T, no ack → abort evaluated at T+TIMEOUT_CYCLES; strobes low and rsp_valid=1 with rsp_error=1 at T+TIMEOUT_CYCLES+1.
- Response fields are registered and hold their value after rsp_valid falls, until the next response.

## Test plan
- Reset mid-transaction:
  - Stimulus: grant a read, then drop reset_n for one cycle while in BUS.
  - Required: all outputs 0 immediately (asynchronous); no rsp_valid after release.
  - Stimulus: then assert req_valid=0b0100.
  - Required: req_ready=0b0100 on the first IDLE cycle.
- Single read, zero wait:
  - Stimulus: req_valid[2]=1, address 0x1000_0040, thread 3; ack next cycle with io_read_data=0xDEADBEEF.
  - Required: req_ready=0b0100 at T; io_read_en and io_address=0x1000_0040 at T+1; at T+2 rsp_valid=1, rsp_requester=2, rsp_thread_idx=3, rsp_read_value=0xDEADBEEF, rsp_error=0.
- Round robin fairness:
  - Stimulus: all four requesters held valid, slave acks immediately, 8 transactions.
  - Required: grant order 0,1,2,3,0,1,2,3; grants 2 cycles apart.
- Variable latency store:
  - Stimulus: store 0x12345678 to 0x20; ack delayed 5 cycles.
  - Required: io_write_en, io_address=0x20, io_write_data=0x12345678 stable for 5 cycles; rsp_read_value=0, rsp_error=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, read, never ack.
  - Required: strobe high T+1..T+8; at T+9 rsp_valid=1, rsp_error=1, rsp_read_value=0.
  - Stimulus: repeat with ack at T+8.
  - Required: normal response, rsp_error=0.
- Requester withdrawal:
  - Stimulus: req_valid[1] pulses for one cycle while the block is in BUS.
  - Required: never granted.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin arbiter merging core IO requests onto one external IO bus
module io_bus_arbiter #(
  parameter int NUM_REQUESTERS   = 4,
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_IDX_WIDTH = 2,
  parameter int TIMEOUT_CYCLES   = 256,
  localparam int REQ_IDX_WIDTH   = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [NUM_REQUESTERS-1:0]                    req_valid,
  input  logic [NUM_REQUESTERS-1:0]                    req_is_store,
  input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0]         req_address,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]         req_write_data,
  input  logic [NUM_REQUESTERS*THREAD_IDX_WIDTH-1:0]   req_thread_idx,
  output logic [NUM_REQUESTERS-1:0]                    req_ready,
  output logic                                         rsp_valid,
  output logic [REQ_IDX_WIDTH-1:0]                     rsp_requester,
  output logic [THREAD_IDX_WIDTH-1:0]                  rsp_thread_idx,
  output logic [DATA_WIDTH-1:0]                        rsp_read_value,
  output logic                                         rsp_error,
  output logic                                         io_read_en,
  output logic                                         io_write_en,
  output logic [ADDR_WIDTH-1:0]                        io_address,
  output logic [DATA_WIDTH-1:0]                        io_write_data,
  input  logic                                         io_ack,
  input  logic [DATA_WIDTH-1:0]                        io_read_data
);

  // Counter is wide enough to hold TIMEOUT_CYCLES itself; with the timeout
  // disabled it collapses to a single saturating bit that is never compared.
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TERM_COUNT =
    CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [REQ_IDX_WIDTH-1:0] LAST_IDX = REQ_IDX_WIDTH'(NUM_REQUESTERS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t                      state;
  logic [REQ_IDX_WIDTH-1:0]    last_grant;
  logic [REQ_IDX_WIDTH-1:0]    cur_requester;
  logic [THREAD_IDX_WIDTH-1:0] cur_thread;
  logic [CNT_WIDTH-1:0]        timeout_count;

  logic                        grant_found;
  logic [REQ_IDX_WIDTH-1:0]    grant_idx;
  logic [REQ_IDX_WIDTH-1:0]    cand_idx;
  int                          cand_pos;

  logic                        sel_is_store;
  logic [ADDR_WIDTH-1:0]       sel_address;
  logic [DATA_WIDTH-1:0]       sel_write_data;
  logic [THREAD_IDX_WIDTH-1:0] sel_thread;

  // Round-robin search: first valid requester at or after last_grant+1, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    cand_pos    = 0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand_pos = int'(last_grant) + 1 + i;
      if (cand_pos >= NUM_REQUESTERS) begin
        cand_pos = cand_pos - NUM_REQUESTERS;
      end
      cand_idx = REQ_IDX_WIDTH'(cand_pos);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Accept pulse is only offered while the bus is free.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Pick the winning requester's payload out of the flattened request buses.
  always_comb begin
    sel_is_store   = req_is_store[grant_idx];
    sel_address    = req_address[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_write_data = req_write_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_thread     = req_thread_idx[int'(grant_idx)*THREAD_IDX_WIDTH +: THREAD_IDX_WIDTH];
  end

  // Transaction FSM: latch a grant, hold the strobe until ack or timeout, then respond.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_grant     <= LAST_IDX;
      cur_requester  <= '0;
      cur_thread     <= '0;
      timeout_count  <= '0;
      io_read_en     <= 1'b0;
      io_write_en    <= 1'b0;
      io_address     <= '0;
      io_write_data  <= '0;
      rsp_valid      <= 1'b0;
      rsp_requester  <= '0;
      rsp_thread_idx <= '0;
      rsp_read_value <= '0;
      rsp_error      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            state         <= BUS;
            last_grant    <= grant_idx;
            cur_requester <= grant_idx;
            cur_thread    <= sel_thread;
            io_address    <= sel_address;
            io_write_data <= sel_write_data;
            io_write_en   <= sel_is_store;
            io_read_en    <= !sel_is_store;
            timeout_count <= '0;
          end
        end
        BUS: begin
          if (io_ack) begin
            // Ack has priority over a coincident terminal count.
            state          <= IDLE;
            io_read_en     <= 1'b0;
            io_write_en    <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_requester  <= cur_requester;
            rsp_thread_idx <= cur_thread;
            rsp_read_value <= io_write_en ? '0 : io_read_data;
            rsp_error      <= 1'b0;
          end else if (TIMEOUT_EN && timeout_count == TERM_COUNT) begin
            state          <= IDLE;
            io_read_en     <= 1'b0;
            io_write_en    <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_requester  <= cur_requester;
            rsp_thread_idx <= cur_thread;
            rsp_read_value <= '0;
            rsp_error      <= 1'b1;
          end else if (timeout_count != '1) begin
            timeout_count <= timeout_count + CNT_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - directed self-checking bench for io_bus_arbiter
module tb_io_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_is_store;
  logic [N*AW-1:0] req_address;
  logic [N*DW-1:0] req_write_data;
  logic [N*TW-1:0] req_thread_idx;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_requester;
  logic [TW-1:0]   rsp_thread_idx;
  logic [DW-1:0]   rsp_read_value;
  logic            rsp_error;
  logic            io_read_en;
  logic            io_write_en;
  logic [AW-1:0]   io_address;
  logic [DW-1:0]   io_write_data;
  logic            io_ack;
  logic [DW-1:0]   io_read_data;

  int total = 0;
  int bad   = 0;

  io_bus_arbiter #(
    .NUM_REQUESTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .THREAD_IDX_WIDTH(TW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_is_store(req_is_store), .req_address(req_address),
    .req_write_data(req_write_data), .req_thread_idx(req_thread_idx), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_requester(rsp_requester), .rsp_thread_idx(rsp_thread_idx),
    .rsp_read_value(rsp_read_value), .rsp_error(rsp_error),
    .io_read_en(io_read_en), .io_write_en(io_write_en), .io_address(io_address),
    .io_write_data(io_write_data), .io_ack(io_ack), .io_read_data(io_read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled mid-cycle.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic st, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [TW-1:0] t);
    req_valid[idx]              = 1'b1;
    req_is_store[idx]           = st;
    req_address[idx*AW +: AW]   = a;
    req_write_data[idx*DW +: DW] = d;
    req_thread_idx[idx*TW +: TW] = t;
  endtask

  initial begin
    logic saw_rsp;
    logic [3:0] exp_ready;
    reset_n        = 1'b0;
    req_valid      = '0;
    req_is_store   = '0;
    req_address    = '0;
    req_write_data = '0;
    req_thread_idx = '0;
    io_ack         = 1'b0;
    io_read_data   = '0;
    @(negedge clk);
    tick;

    // Reset state
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_read_en", io_read_en, 0);
    check("rst_write_en", io_write_en, 0);
    check("rst_address", io_address, 0);
    check("rst_rsp_value", rsp_read_value, 0);
    check("rst_rsp_error", rsp_error, 0);
    reset_n = 1'b1;
    tick;

    // Single read, zero-wait slave
    set_req(2, 1'b0, 32'h1000_0040, 32'h0, 2'd3);
    #1;
    check("rd_ready", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    check("rd_read_en", io_read_en, 1);
    check("rd_write_en", io_write_en, 0);
    check("rd_address", io_address, 32'h1000_0040);
    check("rd_ready_bus", req_ready, 0);
    io_ack = 1'b1;
    io_read_data = 32'hDEAD_BEEF;
    tick;
    io_ack = 1'b0;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_req", rsp_requester, 2);
    check("rd_rsp_thr", rsp_thread_idx, 3);
    check("rd_rsp_value", rsp_read_value, 32'hDEAD_BEEF);
    check("rd_rsp_error", rsp_error, 0);
    check("rd_strobe_drop", io_read_en, 0);
    tick;
    check("rd_rsp_pulse", rsp_valid, 0);
    check("rd_rsp_hold", rsp_read_value, 32'hDEAD_BEEF);

    // Reset mid-transaction (last_grant=2, so requester 0 wins next)
    set_req(0, 1'b0, 32'h44, 32'h0, 2'd1);
    #1;
    check("mr_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    check("mr_read_en", io_read_en, 1);
    reset_n = 1'b0;
    #1;
    check("mr_async_read_en", io_read_en, 0);
    check("mr_async_address", io_address, 0);
    check("mr_async_rsp_req", rsp_requester, 0);
    check("mr_async_rsp_value", rsp_read_value, 0);
    check("mr_async_ready", req_ready, 0);
    tick;
    reset_n = 1'b1;
    saw_rsp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      saw_rsp = saw_rsp | rsp_valid;
    end
    check("mr_no_rsp", saw_rsp, 0);
    set_req(2, 1'b0, 32'h80, 32'h0, 2'd1);
    #1;
    check("mr_ready_after", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    io_ack = 1'b1;
    tick;
    io_ack = 1'b0;
    check("mr_rsp_req", rsp_requester, 2);

    // Requester 3 alone brings last_grant to 3
    set_req(3, 1'b0, 32'h0, 32'h0, 2'd0);
    #1;
    check("wrap_ready", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    io_ack = 1'b1;
    tick;

    // Round robin: all four held valid, zero-wait slave
    for (int r = 0; r < N; r++) begin
      set_req(r, 1'b0, AW'(r * 32'h100), 32'h0, TW'(r));
    end
    io_ack = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      exp_ready = (i % 2 == 0) ? (4'b0001 << ((i / 2) % 4)) : 4'b0000;
      check($sformatf("rr_ready_%0d", i), req_ready, exp_ready);
      if (i % 2 == 1) begin
        check($sformatf("rr_addr_%0d", i), io_address, ((i / 2) % 4) * 32'h100);
      end else if (i > 0) begin
        check($sformatf("rr_rsp_req_%0d", i), rsp_requester, ((i / 2) + 3) % 4);
      end
      tick;
    end
    req_valid = '0;
    io_ack = 1'b0;
    #1;
    check("rr_last_rsp", rsp_requester, 3);
    tick;

    // Variable-latency store: ack on the fifth strobe cycle
    set_req(1, 1'b1, 32'h20, 32'h1234_5678, 2'd2);
    #1;
    check("st_ready", req_ready, 4'b0010);
    tick;
    req_valid = '0;
    for (int j = 0; j < 5; j++) begin
      check($sformatf("st_we_%0d", j), io_write_en, 1);
      check($sformatf("st_re_%0d", j), io_read_en, 0);
      check($sformatf("st_addr_%0d", j), io_address, 32'h20);
      check($sformatf("st_data_%0d", j), io_write_data, 32'h1234_5678);
      check($sformatf("st_rspv_%0d", j), rsp_valid, 0);
      if (j == 4) begin
        io_ack = 1'b1;
        io_read_data = 32'hFFFF_FFFF;
      end
      tick;
    end
    io_ack = 1'b0;
    check("st_rsp_valid", rsp_valid, 1);
    check("st_rsp_value", rsp_read_value, 0);
    check("st_rsp_error", rsp_error, 0);
    check("st_rsp_req", rsp_requester, 1);
    check("st_rsp_thr", rsp_thread_idx, 2);
    check("st_we_drop", io_write_en, 0);
    tick;

    // Timeout: read never acked (last_grant=1, requester 3 is the only one valid)
    io_read_data = 32'h5555_5555;
    set_req(3, 1'b0, 32'h300, 32'h0, 2'd1);
    #1;
    check("to_ready", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    for (int k = 1; k <= TO; k++) begin
      check($sformatf("to_strobe_T%0d", k), io_read_en, 1);
      check($sformatf("to_rspv_T%0d", k), rsp_valid, 0);
      tick;
    end
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_error", rsp_error, 1);
    check("to_rsp_value", rsp_read_value, 0);
    check("to_rsp_req", rsp_requester, 3);
    check("to_strobe_drop", io_read_en, 0);
    tick;

    // Ack coincides with terminal count: ack wins
    set_req(0, 1'b0, 32'h400, 32'h0, 2'd2);
    #1;
    check("tc_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    for (int k = 1; k <= TO; k++) begin
      check($sformatf("tc_strobe_T%0d", k), io_read_en, 1);
      if (k == TO) begin
        io_ack = 1'b1;
        io_read_data = 32'hCAFE_F00D;
      end
      tick;
    end
    io_ack = 1'b0;
    check("tc_rsp_valid", rsp_valid, 1);
    check("tc_rsp_error", rsp_error, 0);
    check("tc_rsp_value", rsp_read_value, 32'hCAFE_F00D);
    check("tc_rsp_thr", rsp_thread_idx, 2);
    tick;

    // Withdrawal: requester 1 pulses valid for one cycle while the bus is busy
    set_req(2, 1'b0, 32'h500, 32'h0, 2'd0);
    #1;
    check("wd_ready", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    req_valid[1] = 1'b1;
    #1;
    check("wd_ready_bus", req_ready, 0);
    tick;
    req_valid[1] = 1'b0;
    check("wd_ready_bus2", req_ready, 0);
    io_ack = 1'b1;
    tick;
    io_ack = 1'b0;
    check("wd_rsp_req", rsp_requester, 2);
    check("wd_never_granted", req_ready, 0);
    tick;
    check("wd_still_idle", io_read_en, 0);

    // io_ack while idle is ignored
    io_ack = 1'b1;
    tick;
    tick;
    io_ack = 1'b0;
    check("idle_ack_rsp", rsp_valid, 0);
    check("idle_ack_strobe", io_read_en | io_write_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
